// File: rtl/blit_pkg.sv
// blit_pkg: shared types, defaults and bus helpers for the blit arbiter
package blit_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int COORD_W_DEF = 11;
  localparam int PIX_W_DEF = 8;
  localparam int BUS_MAX = 256;
  function automatic logic [31:0] slice_of(input logic [BUS_MAX-1:0] bus, input int idx, input int w);
    return 32'(bus >> (idx * w)) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/blit_arbiter_rr.sv
// rr_arbiter: combinational rotating-priority picker starting at ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    any = |req;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/blit_arbiter.sv
// blit_arbiter: round-robin share of the framebuffer burst writer among rectangle requesters
module blit_arbiter
  import blit_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int COORD_W = COORD_W_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*COORD_W-1:0]   req_x,
  input  logic [NUM_REQ*COORD_W-1:0]   req_y,
  input  logic [NUM_REQ*COORD_W-1:0]   req_width,
  input  logic [NUM_REQ*COORD_W-1:0]   req_height,
  input  logic [NUM_REQ*PIX_W-1:0]     req_pixel_data,
  input  logic [NUM_REQ-1:0]           req_pixel_valid,
  input  logic [NUM_REQ-1:0]           req_draw,
  output logic [NUM_REQ-1:0]           req_pixel_ready,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [COORD_W-1:0]           pixel_x,
  output logic [COORD_W-1:0]           pixel_y,
  output logic [COORD_W-1:0]           width,
  output logic [COORD_W-1:0]           height,
  output logic [PIX_W-1:0]             pixel_data,
  output logic                         pixel_valid,
  output logic                         draw,
  input  logic                         pixel_ready,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, nstate;
  logic [IW-1:0] rr_ptr, pick_idx;
  logic [NUM_REQ-1:0] pick, g_hot;
  logic any, accept, last, run;
  logic [COORD_W-1:0] x0, y0, col, row;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(pick),
    .idx  (pick_idx),
    .any  (any)
  );
  assign run = state == RUN;
  assign g_hot = NUM_REQ'(1) << grant_id;
  assign accept = pixel_valid & pixel_ready;
  assign last = (col == width) && (row == height);
  assign pixel_x = x0 + col;
  assign pixel_y = y0 + row;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nstate;
  always_comb
    nstate = (state == IDLE) ? (any ? RUN : IDLE) :
             run ? ((accept && last) ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state != IDLE;
    req_ready = (state == IDLE) ? pick : '0;
    pixel_valid = run & req_pixel_valid[grant_id];
    draw = run & req_draw[grant_id];
    pixel_data = run ? PIX_W'(slice_of(BUS_MAX'(req_pixel_data), int'(grant_id), PIX_W)) : '0;
    req_pixel_ready = accept ? g_hot : '0;
    req_done = (state == DONE) ? g_hot : '0;
  end
  // the final accept leaves the counters on the last pixel; the next grant reloads them
  always_ff @(posedge clk)
    if (reset) begin
      x0 <= '0;
      y0 <= '0;
      width <= '0;
      height <= '0;
      col <= '0;
      row <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
    end else if (state == IDLE && any) begin
      x0 <= COORD_W'(slice_of(BUS_MAX'(req_x), int'(pick_idx), COORD_W));
      y0 <= COORD_W'(slice_of(BUS_MAX'(req_y), int'(pick_idx), COORD_W));
      width <= COORD_W'(slice_of(BUS_MAX'(req_width), int'(pick_idx), COORD_W));
      height <= COORD_W'(slice_of(BUS_MAX'(req_height), int'(pick_idx), COORD_W));
      col <= '0;
      row <= '0;
      grant_id <= pick_idx;
      rr_ptr <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end else if (accept && !last) begin
      col <= (col == width) ? '0 : col + 1'b1;
      row <= (col == width) ? row + 1'b1 : row;
    end
endmodule

// File: tb/tb_blit_arbiter.sv
// tb_blit_arbiter: directed corner sequences, a grant-order table and a randomized transaction-model check
module tb_blit_arbiter;
  localparam int N = 4, CW = 11, PW = 8;
  logic clk = 0, reset = 1, pixel_ready = 0;
  logic [N-1:0] req_valid = '0, req_pixel_valid = '0, req_draw = '0;
  logic [CW-1:0] rx[N], ry[N], rw[N], rh[N];
  logic [PW-1:0] rd[N];
  logic [N*CW-1:0] req_x, req_y, req_width, req_height;
  logic [N*PW-1:0] req_pixel_data;
  logic [N-1:0] req_ready, req_pixel_ready, req_done;
  logic [CW-1:0] pixel_x, pixel_y, width, height;
  logic [PW-1:0] pixel_data;
  logic pixel_valid, draw, busy;
  logic [1:0] grant_id;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  always_comb begin
    req_x = '0;
    req_y = '0;
    req_width = '0;
    req_height = '0;
    req_pixel_data = '0;
    for (int i = 0; i < N; i++) begin
      req_x[i*CW+:CW] = rx[i];
      req_y[i*CW+:CW] = ry[i];
      req_width[i*CW+:CW] = rw[i];
      req_height[i*CW+:CW] = rh[i];
      req_pixel_data[i*PW+:PW] = rd[i];
    end
  end
  blit_arbiter #(.NUM_REQ(N), .COORD_W(CW), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_width(req_width), .req_height(req_height),
    .req_pixel_data(req_pixel_data), .req_pixel_valid(req_pixel_valid), .req_draw(req_draw),
    .req_pixel_ready(req_pixel_ready), .req_done(req_done), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .width(width), .height(height), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .draw(draw), .pixel_ready(pixel_ready), .busy(busy), .grant_id(grant_id)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic do_reset;
    reset = 1;
    req_valid = '0;
    nxt;
    nxt;
    reset = 0;
  endtask
  // transaction model: grant order from a rotating pointer, expected cursor list per command
  bit mon_en = 0;
  int phase = 0, mg = 0, mptr = 0;
  int qx[$], qy[$];
  always @(negedge clk) if (mon_en) begin
    int g;
    g = -1;
    if (phase == 0) begin
      for (int k = 0; k < N; k++) if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      chk("rnd_ready", req_ready, g < 0 ? 0 : (1 << g));
      chk("rnd_idle_done", req_done, 0);
      if (g >= 0) begin
        mg = g;
        mptr = (g + 1) % N;
        for (int r = 0; r <= int'(rh[g]); r++)
          for (int c = 0; c <= int'(rw[g]); c++) begin
            qx.push_back((int'(rx[g]) + c) % 2048);
            qy.push_back((int'(ry[g]) + r) % 2048);
          end
        phase = 1;
      end
    end else if (phase == 1) begin
      chk("rnd_gid", grant_id, mg);
      chk("rnd_pvalid", pixel_valid, req_pixel_valid[mg]);
      if (pixel_valid && pixel_ready) begin
        chk("rnd_px", pixel_x, qx[0]);
        chk("rnd_py", pixel_y, qy[0]);
        chk("rnd_data", pixel_data, rd[mg]);
        chk("rnd_draw", draw, req_draw[mg]);
        chk("rnd_pready", req_pixel_ready, 1 << mg);
        void'(qx.pop_front());
        void'(qy.pop_front());
        if (qx.size() == 0) phase = 2;
      end else chk("rnd_pready_idle", req_pixel_ready, 0);
    end else begin
      chk("rnd_done", req_done, 1 << mg);
      phase = 0;
    end
  end
  typedef struct {logic [N-1:0] mask; int g;} vec_t;
  vec_t tbl[15];
  int bp_pr[7] = '{1, 1, 0, 0, 0, 1, 1};
  int bp_x[7] = '{100, 101, 102, 102, 102, 102, 103};
  initial begin
    int acc;
    for (int i = 0; i < N; i++) begin
      rx[i] = '0; ry[i] = '0; rw[i] = '0; rh[i] = '0; rd[i] = '0;
    end
    do_reset;
    smp;
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_cursor", {pixel_x, pixel_y}, 0);
    chk("rst_size", {width, height}, 0);
    chk("rst_outs", {req_ready, req_pixel_ready, req_done, pixel_valid, draw, pixel_data}, 0);
    // 2x2 rectangle
    nxt;
    rx[0] = 10; ry[0] = 5; rw[0] = 1; rh[0] = 1; rd[0] = 8'hA5;
    req_valid = 4'b0001; req_pixel_valid = '1; req_draw = 4'b0001; pixel_ready = 1;
    smp;
    chk("r2_ready", req_ready, 4'b0001);
    nxt;
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      smp;
      chk("r2_valid", pixel_valid, 1);
      chk("r2_x", pixel_x, 10 + i % 2);
      chk("r2_y", pixel_y, 5 + i / 2);
      chk("r2_data", pixel_data, 8'hA5);
      chk("r2_nodone", req_done, 0);
      nxt;
    end
    smp;
    chk("r2_done", req_done, 4'b0001);
    chk("r2_busy", busy, 1);
    chk("r2_size", {width, height}, {11'd1, 11'd1});
    nxt;
    smp;
    chk("r2_idle", {busy, req_done}, 0);
    // backpressure on a 4x1 line
    nxt;
    rx[1] = 100; ry[1] = 7; rw[1] = 3; rh[1] = 0; req_valid = 4'b0010;
    smp;
    chk("bp_ready", req_ready, 4'b0010);
    nxt;
    req_valid = '0;
    acc = 0;
    for (int j = 0; j < 7; j++) begin
      pixel_ready = bp_pr[j][0];
      smp;
      chk("bp_x", pixel_x, bp_x[j]);
      chk("bp_nodone", req_done, 0);
      if (pixel_valid && pixel_ready) acc++;
      nxt;
    end
    pixel_ready = 1;
    chk("bp_accepts", acc, 4);
    smp;
    chk("bp_done", req_done, 4'b0010);
    nxt;
    // coordinate wrap
    nxt;
    rx[2] = 2047; ry[2] = 9; rw[2] = 1; rh[2] = 0; req_valid = 4'b0100;
    smp;
    chk("wr_ready", req_ready, 4'b0100);
    nxt;
    req_valid = '0;
    smp;
    chk("wr_xy0", {pixel_x, pixel_y}, {11'd2047, 11'd9});
    nxt;
    smp;
    chk("wr_xy1", {pixel_x, pixel_y}, {11'd0, 11'd9});
    nxt;
    smp;
    chk("wr_done", req_done, 4'b0100);
    nxt;
    // reset in the middle of a 16-pixel line
    nxt;
    rx[2] = 50; ry[2] = 20; rw[2] = 15; req_valid = 4'b0100;
    smp;
    chk("mr_ready", req_ready, 4'b0100);
    nxt;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("mr_acc", pixel_valid & pixel_ready, 1);
      nxt;
    end
    reset = 1;
    nxt;
    reset = 0;
    smp;
    chk("mr_busy", busy, 0);
    chk("mr_regs", {grant_id, pixel_x, pixel_y, width, height}, 0);
    chk("mr_outs", {req_ready, req_pixel_ready, req_done, pixel_valid, draw, pixel_data}, 0);
    nxt;
    smp;
    chk("mr_nodone", req_done, 0);
    nxt;
    rw[2] = 0; req_valid = 4'b1100;
    smp;
    chk("mr_ptr0", req_ready, 4'b0100);
    nxt;
    req_valid = '0;
    smp;
    chk("mr_gid", grant_id, 2);
    nxt;
    smp;
    chk("mr_done", req_done, 4'b0100);
    nxt;
    // grant-order table of single-pixel commands
    tbl[0] = '{4'b1111, 0}; tbl[1] = '{4'b1111, 1}; tbl[2] = '{4'b1111, 2};
    tbl[3] = '{4'b1111, 3}; tbl[4] = '{4'b1111, 0}; tbl[5] = '{4'b1010, 1};
    tbl[6] = '{4'b1010, 3}; tbl[7] = '{4'b1010, 1}; tbl[8] = '{4'b1010, 3};
    tbl[9] = '{4'b0100, 2}; tbl[10] = '{4'b0001, 0}; tbl[11] = '{4'b1001, 3};
    tbl[12] = '{4'b1001, 0}; tbl[13] = '{4'b0110, 1}; tbl[14] = '{4'b0110, 2};
    do_reset;
    for (int i = 0; i < N; i++) begin
      rw[i] = 0; rh[i] = 0; rx[i] = CW'(i * 3);
    end
    for (int t = 0; t < 15; t++) begin
      req_valid = tbl[t].mask;
      smp;
      chk("tbl_ready", req_ready, 1 << tbl[t].g);
      nxt;
      req_valid = '0;
      smp;
      chk("tbl_gid", grant_id, tbl[t].g);
      chk("tbl_pready", req_pixel_ready, 1 << tbl[t].g);
      chk("tbl_x", pixel_x, tbl[t].g * 3);
      nxt;
      smp;
      chk("tbl_done", req_done, 1 << tbl[t].g);
      nxt;
    end
    // randomized traffic against the transaction model
    do_reset;
    mptr = 0;
    phase = 0;
    mon_en = 1;
    repeat (3000) begin
      nxt;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = $urandom_range(0, 1) == 1;
        rx[i] = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(2044, 2047)) : CW'($urandom);
        ry[i] = CW'($urandom);
        rw[i] = CW'($urandom_range(0, 3));
        rh[i] = CW'($urandom_range(0, 2));
        rd[i] = PW'($urandom);
        req_draw[i] = $urandom_range(0, 1) == 1;
        req_pixel_valid[i] = $urandom_range(0, 3) != 0;
      end
      pixel_ready = $urandom_range(0, 9) < 7;
    end
    nxt;
    req_valid = '0; req_pixel_valid = '1; pixel_ready = 1;
    repeat (40) nxt;
    chk("rnd_drained", phase, 0);
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
